cp0_event_controller: RTL and testbench

Sequencing controller for coprocessor 0. It owns the Count/Compare timer and synchronises the external interrupt lines. It builds the Cause IP field, raises a held interrupt request to the pipeline, and arbitrates between writeback exceptions, ERET and interrupts. The result is one pipeline flush per event with its redirect target. It sits beside the CP0 register file: it reads Status, software-IP and EPC from it, and supplies Cause.IP/TI back to it and the flush target to IF.

---
 rtl/cp0_event_controller_if.sv | 27 ++
 rtl/cp0_event_controller.sv | 158 +++++++++++++++
 tb/tb_cp0_event_controller.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cp0_event_controller_if.sv
// Writeback-to-CP0 event bus: MTC0 writes, WB commit events, and the
// resulting pipeline flush/redirect going back to the front end.
interface cp0_event_controller_if;
   logic        wb_cp0_we;
   logic [4:0]  wb_cp0_reg;
   logic [2:0]  wb_cp0_sel;
   logic [31:0] wb_cp0_wdata;
   logic        wb_exception_valid;
   logic        wb_eret;
   logic        wb_int_taken;
   logic        flush;
   logic [31:0] flush_target;

   // Pipeline side: drives writeback events, consumes the flush.
   modport master (
      output wb_cp0_we, wb_cp0_reg, wb_cp0_sel, wb_cp0_wdata,
      output wb_exception_valid, wb_eret, wb_int_taken,
      input  flush, flush_target
   );

   // Controller side: consumes writeback events, produces the flush.
   modport slave (
      input  wb_cp0_we, wb_cp0_reg, wb_cp0_sel, wb_cp0_wdata,
      input  wb_exception_valid, wb_eret, wb_int_taken,
      output flush, flush_target
   );
endinterface

// File: rtl/cp0_event_controller.sv
// CP0 event controller: Count/Compare timer, external interrupt
// synchroniser, Cause.IP construction and exception/ERET/interrupt
// arbitration producing one flush per accepted event.
module cp0_event_controller #(
   parameter int SYNC_STAGES = 2,
   parameter int COUNT_DIV   = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [5:0]            ext_int,
   input  logic                  status_ie,
   input  logic                  status_exl,
   input  logic                  status_bev,
   input  logic [7:0]            status_im,
   input  logic [1:0]            cause_sw,
   input  logic [31:0]           epc,
   cp0_event_controller_if.slave wb_bus,
   output logic [31:0]           count_value,
   output logic [31:0]           compare_value,
   output logic [7:0]            cause_ip,
   output logic                  timer_interrupt,
   output logic                  int_request
);

   localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);
   localparam logic [31:0] VEC_BEV    = 32'hBFC0_0380;
   localparam logic [31:0] VEC_NORMAL = 32'h8000_0180;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FLUSH  = 2'd1,
      SETTLE = 2'd2
   } state_t;

   state_t                      state_q, state_d;
   logic [DIV_W-1:0]            div_q, div_d;
   logic [31:0]                 count_q, count_d;
   logic [31:0]                 compare_q, compare_d;
   logic                        ti_q, ti_d;
   logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
   logic                        flush_q, flush_d;
   logic [31:0]                 target_q, target_d;

   logic        count_we;
   logic        compare_we;
   logic        inc;
   logic        ti_set;
   logic        pending;
   logic [31:0] count_inc;
   logic [31:0] exc_vector;

   assign count_we   = wb_bus.wb_cp0_we && (wb_bus.wb_cp0_reg == 5'd9)  && (wb_bus.wb_cp0_sel == 3'd0);
   assign compare_we = wb_bus.wb_cp0_we && (wb_bus.wb_cp0_reg == 5'd11) && (wb_bus.wb_cp0_sel == 3'd0);
   assign inc        = (div_q == DIV_LAST);
   assign count_inc  = count_q + 32'd1;
   assign exc_vector = status_bev ? VEC_BEV : VEC_NORMAL;

   // Timer next state: divider, Count (write beats increment), Compare, TI.
   always_comb begin
      div_d     = div_q;
      count_d   = count_q;
      compare_d = compare_q;
      ti_d      = ti_q;
      ti_set    = 1'b0;
      if (count_we) begin
         div_d   = {DIV_W{1'b0}};
         count_d = wb_bus.wb_cp0_wdata;
         ti_set  = (wb_bus.wb_cp0_wdata == compare_q);
      end else if (inc) begin
         div_d   = {DIV_W{1'b0}};
         count_d = count_inc;
         ti_set  = (count_inc == compare_q);
      end else begin
         div_d   = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
      end
      if (compare_we) begin
         compare_d = wb_bus.wb_cp0_wdata;
         ti_d      = 1'b0;
      end else if (ti_set) begin
         ti_d      = 1'b1;
      end else begin
         ti_d      = ti_q;
      end
   end

   // External interrupt synchroniser chain next state.
   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = ext_int;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   assign cause_ip    = {sync_q[SYNC_STAGES-1][5] | ti_q, sync_q[SYNC_STAGES-1][4:0], cause_sw};
   assign pending     = status_ie && !status_exl && ((cause_ip & status_im) != 8'd0);
   assign int_request = (state_q == RUN) && pending;

   // Event arbitration FSM: exception > ERET > interrupt, one flush per event.
   always_comb begin
      state_d  = state_q;
      flush_d  = 1'b0;
      target_d = target_q;
      case (state_q)
         RUN: begin
            if (wb_bus.wb_exception_valid) begin
               state_d  = FLUSH;
               flush_d  = 1'b1;
               target_d = exc_vector;
            end else if (wb_bus.wb_eret) begin
               state_d  = FLUSH;
               flush_d  = 1'b1;
               target_d = epc;
            end else if (wb_bus.wb_int_taken && pending) begin
               state_d  = FLUSH;
               flush_d  = 1'b1;
               target_d = exc_vector;
            end else begin
               state_d  = RUN;
            end
         end
         FLUSH:   state_d = SETTLE;
         SETTLE:  state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= RUN;
         div_q     <= {DIV_W{1'b0}};
         count_q   <= 32'd0;
         compare_q <= 32'd0;
         ti_q      <= 1'b0;
         sync_q    <= '0;
         flush_q   <= 1'b0;
         target_q  <= 32'd0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
         sync_q    <= sync_d;
         flush_q   <= flush_d;
         target_q  <= target_d;
      end
   end

   assign count_value         = count_q;
   assign compare_value       = compare_q;
   assign timer_interrupt     = ti_q;
   assign wb_bus.flush        = flush_q;
   assign wb_bus.flush_target = target_q;

endmodule

// File: tb/tb_cp0_event_controller.sv
// Directed self-checking bench for cp0_event_controller (SYNC_STAGES=2, COUNT_DIV=2).
module tb_cp0_event_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic [5:0]  ext_int;
   logic        status_ie, status_exl, status_bev;
   logic [7:0]  status_im;
   logic [1:0]  cause_sw;
   logic [31:0] epc;
   logic [31:0] count_value, compare_value;
   logic [7:0]  cause_ip;
   logic        timer_interrupt, int_request;

   int checks = 0;
   int passed = 0;

   cp0_event_controller_if bus ();

   cp0_event_controller #(.SYNC_STAGES(2), .COUNT_DIV(2)) dut (
      .clock(clock), .reset(reset), .ext_int(ext_int),
      .status_ie(status_ie), .status_exl(status_exl), .status_bev(status_bev),
      .status_im(status_im), .cause_sw(cause_sw), .epc(epc),
      .wb_bus(bus.slave),
      .count_value(count_value), .compare_value(compare_value),
      .cause_ip(cause_ip), .timer_interrupt(timer_interrupt),
      .int_request(int_request)
   );

   always #5 clock = ~clock;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic mtc0(input logic [4:0] r, input logic [2:0] s, input logic [31:0] d);
      bus.wb_cp0_we = 1'b1; bus.wb_cp0_reg = r; bus.wb_cp0_sel = s; bus.wb_cp0_wdata = d;
      tick(1);
      bus.wb_cp0_we = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; ext_int = 6'd0; status_ie = 1'b0; status_exl = 1'b0; status_bev = 1'b0;
      status_im = 8'd0; cause_sw = 2'd0; epc = 32'd0;
      bus.wb_cp0_we = 1'b0; bus.wb_cp0_reg = 5'd0; bus.wb_cp0_sel = 3'd0; bus.wb_cp0_wdata = 32'd0;
      bus.wb_exception_valid = 1'b0; bus.wb_eret = 1'b0; bus.wb_int_taken = 1'b0;
      tick(3);
      checks++; if (count_value !== 32'd0) $display("FAIL rst_count got %h exp 0", count_value); else passed++;
      checks++; if (timer_interrupt !== 1'b0 || bus.flush !== 1'b0 || int_request !== 1'b0)
         $display("FAIL rst_flags got ti=%b fl=%b ir=%b exp 0", timer_interrupt, bus.flush, int_request); else passed++;
      checks++; if (bus.flush_target !== 32'd0 || cause_ip !== 8'd0)
         $display("FAIL rst_target got %h ip=%h exp 0", bus.flush_target, cause_ip); else passed++;
      reset = 1'b0;
      tick(10);
      checks++; if (count_value !== 32'd5) $display("FAIL count_10cyc got %0d exp 5", count_value); else passed++;
      checks++; if (compare_value !== 32'd0 || timer_interrupt !== 1'b0)
         $display("FAIL cmp_10cyc got %h ti=%b exp 0", compare_value, timer_interrupt); else passed++;
   endtask

   task automatic test_timer();
      mtc0(5'd11, 3'd0, 32'd3);
      checks++; if (compare_value !== 32'd3) $display("FAIL cmp_write got %h exp 3", compare_value); else passed++;
      mtc0(5'd9, 3'd0, 32'd0);
      checks++; if (count_value !== 32'd0 || timer_interrupt !== 1'b0)
         $display("FAIL count_write got %h ti=%b exp 0/0", count_value, timer_interrupt); else passed++;
      tick(5);
      checks++; if (count_value !== 32'd2 || timer_interrupt !== 1'b0)
         $display("FAIL ti_before got %h ti=%b exp 2/0", count_value, timer_interrupt); else passed++;
      tick(1);
      checks++; if (count_value !== 32'd3 || timer_interrupt !== 1'b1 || cause_ip[7] !== 1'b1)
         $display("FAIL ti_rise got %h ti=%b ip7=%b exp 3/1/1", count_value, timer_interrupt, cause_ip[7]); else passed++;
      tick(4);
      checks++; if (timer_interrupt !== 1'b1) $display("FAIL ti_hold got %b exp 1", timer_interrupt); else passed++;
      mtc0(5'd11, 3'd0, 32'h100);
      checks++; if (timer_interrupt !== 1'b0 || compare_value !== 32'h100)
         $display("FAIL ti_clear got ti=%b cmp=%h exp 0/100", timer_interrupt, compare_value); else passed++;
      mtc0(5'd9, 3'd1, 32'hDEAD_0000);
      checks++; if (count_value[31:16] === 16'hDEAD) $display("FAIL sel_ignore got %h exp not DEADxxxx", count_value); else passed++;
   endtask

   task automatic test_interrupt();
      status_ie = 1'b1; status_exl = 1'b0; status_im = 8'h04;
      ext_int = 6'b000001;
      tick(1);
      checks++; if (int_request !== 1'b0) $display("FAIL sync_stage1 got %b exp 0", int_request); else passed++;
      tick(1);
      checks++; if (int_request !== 1'b1 || cause_ip[2] !== 1'b1)
         $display("FAIL sync_stage2 got ir=%b ip=%h exp 1", int_request, cause_ip); else passed++;
      bus.wb_int_taken = 1'b1;
      tick(1);
      bus.wb_int_taken = 1'b0;
      checks++; if (bus.flush !== 1'b1 || bus.flush_target !== 32'h8000_0180 || int_request !== 1'b0)
         $display("FAIL int_flush got fl=%b tgt=%h ir=%b exp 1/80000180/0", bus.flush, bus.flush_target, int_request); else passed++;
      tick(1);
      checks++; if (bus.flush !== 1'b0 || int_request !== 1'b0)
         $display("FAIL int_settle got fl=%b ir=%b exp 0/0", bus.flush, int_request); else passed++;
      tick(1);
      checks++; if (int_request !== 1'b1) $display("FAIL int_reassert got %b exp 1", int_request); else passed++;
      ext_int = 6'd0;
      tick(2);
      checks++; if (int_request !== 1'b0) $display("FAIL int_drop got %b exp 0", int_request); else passed++;
   endtask

   task automatic test_priority();
      status_bev = 1'b1; epc = 32'h8000_1234;
      bus.wb_exception_valid = 1'b1; bus.wb_eret = 1'b1;
      tick(1);
      bus.wb_exception_valid = 1'b0;
      checks++; if (bus.flush !== 1'b1 || bus.flush_target !== 32'hBFC0_0380)
         $display("FAIL prio_exc got fl=%b tgt=%h exp 1/BFC00380", bus.flush, bus.flush_target); else passed++;
      tick(1);
      checks++; if (bus.flush !== 1'b0) $display("FAIL eret_in_flush got %b exp 0", bus.flush); else passed++;
      tick(1);
      bus.wb_eret = 1'b0;
      checks++; if (bus.flush !== 1'b0) $display("FAIL eret_in_settle got %b exp 0", bus.flush); else passed++;
      tick(1);
      checks++; if (bus.flush !== 1'b0) $display("FAIL no_second_flush got %b exp 0", bus.flush); else passed++;
      status_bev = 1'b0;
   endtask

   task automatic test_eret_reset();
      epc = 32'h8000_1234;
      bus.wb_eret = 1'b1;
      tick(1);
      bus.wb_eret = 1'b0;
      checks++; if (bus.flush !== 1'b1 || bus.flush_target !== 32'h8000_1234)
         $display("FAIL eret_flush got fl=%b tgt=%h exp 1/80001234", bus.flush, bus.flush_target); else passed++;
      tick(1);
      checks++; if (bus.flush !== 1'b0) $display("FAIL eret_one_cycle got %b exp 0", bus.flush); else passed++;
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      checks++; if (bus.flush !== 1'b0 || bus.flush_target !== 32'd0 || count_value !== 32'd0 ||
                    compare_value !== 32'd0 || timer_interrupt !== 1'b0 || int_request !== 1'b0 || cause_ip !== 8'd0)
         $display("FAIL settle_reset got fl=%b tgt=%h cnt=%h cmp=%h ti=%b ir=%b ip=%h exp all 0",
                  bus.flush, bus.flush_target, count_value, compare_value, timer_interrupt, int_request, cause_ip); else passed++;
      bus.wb_eret = 1'b1;
      tick(1);
      bus.wb_eret = 1'b0;
      checks++; if (bus.flush !== 1'b1) $display("FAIL run_after_reset got %b exp 1", bus.flush); else passed++;
      tick(2);
   endtask

   task automatic test_wrap();
      status_ie = 1'b0;
      mtc0(5'd9, 3'd0, 32'hFFFF_FFFF);
      tick(1);
      checks++; if (count_value !== 32'hFFFF_FFFF || timer_interrupt !== 1'b0)
         $display("FAIL wrap_before got %h ti=%b exp FFFFFFFF/0", count_value, timer_interrupt); else passed++;
      tick(1);
      checks++; if (count_value !== 32'd0 || timer_interrupt !== 1'b1)
         $display("FAIL wrap_ti got %h ti=%b exp 0/1", count_value, timer_interrupt); else passed++;
      bus.wb_int_taken = 1'b1;
      tick(1);
      bus.wb_int_taken = 1'b0;
      checks++; if (bus.flush !== 1'b0) $display("FAIL taken_no_pending got %b exp 0", bus.flush); else passed++;
      mtc0(5'd11, 3'd0, 32'h50);
      checks++; if (timer_interrupt !== 1'b0) $display("FAIL cmp_clear2 got %b exp 0", timer_interrupt); else passed++;
      mtc0(5'd9, 3'd0, 32'h50);
      checks++; if (timer_interrupt !== 1'b1 || count_value !== 32'h50)
         $display("FAIL count_eq_write got ti=%b cnt=%h exp 1/50", timer_interrupt, count_value); else passed++;
   endtask

   initial begin
      test_reset();
      test_timer();
      test_interrupt();
      test_priority();
      test_eret_reset();
      test_wrap();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
